// File: rtl/int_xbar_sync.sv
// int_xbar_sync -- interrupt line gatherer for the PLIC/CLINT side.
//
// Each of NUM_INT asynchronous interrupt sources is brought onto the local
// clock through a SYNC_STAGES-deep synchroniser. Level lines (EDGE_MASK bit 0)
// pass the synchronised value straight through. Edge lines (EDGE_MASK bit 1)
// latch a rising edge into a pending bit that software clears with a one-cycle
// clear pulse. A second rise while still pending raises a sticky overrun flag.
// any_out is the OR of the presented vector.
//
// Optional feature macro: INT_XBAR_MASK_EN
//   When defined, an int_mask port is present. It gates int_out and any_out
//   only; the pending and overrun state keeps capturing underneath the mask.
//
// Ports:
//   clock     in   1        block clock
//   reset_n   in   1        asynchronous reset, active low
//   int_in    in   NUM_INT  raw interrupt sources, asynchronous to clock
//   clear     in   NUM_INT  per-line clear pulse (edge lines only)
//   int_mask  in   NUM_INT  1 = suppress line at output (INT_XBAR_MASK_EN only)
//   int_out   out  NUM_INT  synchronised / captured interrupt vector
//   overrun   out  NUM_INT  sticky: edge arrived while line already pending
//   any_out   out  1        OR of int_out
module int_xbar_sync #(
  parameter int                 NUM_INT     = 5,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [NUM_INT-1:0] EDGE_MASK   = 5'b00110
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_INT-1:0] int_in,
  input  logic [NUM_INT-1:0] clear,
`ifdef INT_XBAR_MASK_EN
  input  logic [NUM_INT-1:0] int_mask,
`endif
  output logic [NUM_INT-1:0] int_out,
  output logic [NUM_INT-1:0] overrun,
  output logic               any_out
);

  // Refuse to elaborate with out-of-range parameters.
  if ((SYNC_STAGES < 32'sd1) || (SYNC_STAGES > 32'sd4)) begin : g_bad_sync
    $error("int_xbar_sync: SYNC_STAGES must be in 1..4");
  end
  if ((NUM_INT < 32'sd1) || (NUM_INT > 32'sd64)) begin : g_bad_num
    $error("int_xbar_sync: NUM_INT must be in 1..64");
  end

  // Stage 0 samples int_in; the last stage is the synchronised line value.
  logic [NUM_INT-1:0] sync_q [SYNC_STAGES];
  logic [NUM_INT-1:0] sync_d [SYNC_STAGES];
  logic [NUM_INT-1:0] prev_q,    prev_d;
  logic [NUM_INT-1:0] pending_q, pending_d;
  logic [NUM_INT-1:0] overrun_q, overrun_d;
  logic [NUM_INT-1:0] sync_s;
  logic [NUM_INT-1:0] rise_s;
  logic [NUM_INT-1:0] raw_out_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Synchroniser shift: pure flop chain, nothing between stages.
  always_comb begin
    sync_d[0] = int_in;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // Edge detection, pending latch and overrun next-state for edge lines.
  always_comb begin
    prev_d    = sync_s & EDGE_MASK;
    rise_s    = sync_s & ~prev_q & EDGE_MASK;
    pending_d = pending_q;
    overrun_d = overrun_q;
    for (int i = 0; i < NUM_INT; i++) begin
      if (EDGE_MASK[i]) begin
        // A rise beats a simultaneous clear so no event is ever dropped.
        if (rise_s[i]) begin
          pending_d[i] = 1'b1;
        end else if (clear[i]) begin
          pending_d[i] = 1'b0;
        end else begin
          pending_d[i] = pending_q[i];
        end
        // Overrun only when a new edge lands on an un-cleared pending bit.
        if (rise_s[i] && pending_q[i] && !clear[i]) begin
          overrun_d[i] = 1'b1;
        end else if (clear[i]) begin
          overrun_d[i] = 1'b0;
        end else begin
          overrun_d[i] = overrun_q[i];
        end
      end else begin
        pending_d[i] = 1'b0;
        overrun_d[i] = 1'b0;
      end
    end
  end

  // State registers; reset clears every flop immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= {NUM_INT{1'b0}};
      end
      prev_q    <= {NUM_INT{1'b0}};
      pending_q <= {NUM_INT{1'b0}};
      overrun_q <= {NUM_INT{1'b0}};
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      prev_q    <= prev_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  // Level lines show the synchronised input, edge lines the pending latch.
  assign raw_out_s = (sync_s & ~EDGE_MASK) | (pending_q & EDGE_MASK);

`ifdef INT_XBAR_MASK_EN
  // Mask gates the output only, so unmasking exposes held events at once.
  assign int_out = raw_out_s & ~int_mask;
`else
  assign int_out = raw_out_s;
`endif

  assign overrun = overrun_q;
  assign any_out = |int_out;

endmodule

// File: tb/tb_int_xbar_sync.sv
`timescale 1ns/1ps
// Bench for int_xbar_sync: directed scenarios followed by randomized traffic,
// all compared against a cycle-level reference model of the interrupt rules.
module tb_int_xbar_sync;

  localparam int            N  = 5;
  localparam int            S  = 2;
  localparam logic [N-1:0]  EM = 5'b00110;

  logic         clock   = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] int_in  = 5'd0;
  logic [N-1:0] clear   = 5'd0;
  logic [N-1:0] mask_v  = 5'd0;
  logic [N-1:0] int_out;
  logic [N-1:0] overrun;
  logic         any_out;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  int_xbar_sync #(.NUM_INT(N), .SYNC_STAGES(S), .EDGE_MASK(EM)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .int_in  (int_in),
    .clear   (clear),
`ifdef INT_XBAR_MASK_EN
    .int_mask(mask_v),
`endif
    .int_out (int_out),
    .overrun (overrun),
    .any_out (any_out)
  );

  // Reference model: a queue of past samples gives the synchronised value,
  // and per-line flags follow the capture / clear / overrun rules.
  logic [N-1:0] m_s, m_prev, m_pend, m_ovr;
  logic [N-1:0] m_q[$];

  function automatic void m_reset();
    m_q.delete();
    for (int k = 0; k < S - 1; k++) m_q.push_back(5'd0);
    m_s    = 5'd0;
    m_prev = 5'd0;
    m_pend = 5'd0;
    m_ovr  = 5'd0;
  endfunction

  function automatic void m_step(input logic [N-1:0] din, input logic [N-1:0] clr);
    logic r;
    for (int i = 0; i < N; i++) begin
      if (EM[i]) begin
        r = m_s[i] & ~m_prev[i];
        if (r && m_pend[i] && !clr[i]) m_ovr[i] = 1'b1;
        else if (clr[i])               m_ovr[i] = 1'b0;
        if (r)                         m_pend[i] = 1'b1;
        else if (clr[i])               m_pend[i] = 1'b0;
      end
    end
    m_prev = m_s;
    m_q.push_back(din);
    m_s = m_q.pop_front();
  endfunction

  function automatic logic [N-1:0] exp_out();
    return ((m_s & ~EM) | (m_pend & EM)) & ~mask_v;
  endfunction

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: model advances on the rising edge, outputs checked on the falling edge.
  task automatic tick(input string tag);
    @(posedge clock);
    if (!reset_n) m_reset();
    else          m_step(int_in, clear);
    @(negedge clock);
    chk({tag, ":out"}, int_out, exp_out());
    chk({tag, ":ovr"}, overrun, m_ovr);
    chk({tag, ":any"}, N'(any_out), N'(|exp_out()));
  endtask

  int hold [N];

  initial begin
    m_reset();

    // 1 Reset with all inputs high, then release and watch the latencies.
    int_in = 5'h1F;
    repeat (5) tick("t1_rst");
    chk("t1_rst_out", int_out, 5'd0);
    chk("t1_rst_ovr", overrun, 5'd0);
    reset_n = 1'b1;
    tick("t1_r1"); chk("t1_lat1", int_out, 5'b00000);
    tick("t1_r2"); chk("t1_lat2", int_out, 5'b11001);
    tick("t1_r3"); chk("t1_lat3", int_out, 5'b11111);

    // 2 Edge capture on line 1 and software clear.
    int_in = 5'd0; clear = EM;
    tick("t2_clr"); clear = 5'd0;
    repeat (3) tick("t2_idle");
    int_in[1] = 1'b1;
    tick("t2_a"); chk("t2_c1", N'(int_out[1]), 5'd0);
    tick("t2_b"); chk("t2_c2", N'(int_out[1]), 5'd0);
    int_in[1] = 1'b0;
    tick("t2_c"); chk("t2_c3", N'(int_out[1]), 5'd1);
    repeat (4) tick("t2_hold");
    chk("t2_held", N'(int_out[1]), 5'd1);
    clear[1] = 1'b1;
    tick("t2_clear"); clear = 5'd0;
    chk("t2_cleared", int_out, 5'd0);
    chk("t2_any0", N'(any_out), 5'd0);

    // 3 Clear arriving in the same cycle as the rise must lose.
    int_in[2] = 1'b1;
    tick("t3_a"); tick("t3_b");
    clear[2] = 1'b1;
    tick("t3_c"); clear = 5'd0;
    chk("t3_setwins", N'(int_out[2]), 5'd1);
    chk("t3_noovr", N'(overrun[2]), 5'd0);
    int_in[2] = 1'b0;
    repeat (3) tick("t3_idle");
    clear[2] = 1'b1;
    tick("t3_clr"); clear = 5'd0;

    // 4 Two rises on line 1 without a clear produce overrun.
    int_in[1] = 1'b1; repeat (2) tick("t4_h1");
    int_in[1] = 1'b0; repeat (3) tick("t4_l1");
    int_in[1] = 1'b1; repeat (2) tick("t4_h2");
    int_in[1] = 1'b0; tick("t4_l2");
    chk("t4_ovr", N'(overrun[1]), 5'd1);
    chk("t4_pend", N'(int_out[1]), 5'd1);
    clear[1] = 1'b1;
    tick("t4_clr"); clear = 5'd0;
    chk("t4_ovr0", N'(overrun[1]), 5'd0);
    chk("t4_pend0", N'(int_out[1]), 5'd0);

`ifdef INT_XBAR_MASK_EN
    // 5 Mask hides a captured edge; dropping it exposes the event at once.
    mask_v = 5'b00010;
    int_in[1] = 1'b1; repeat (2) tick("t5_h");
    int_in[1] = 1'b0; tick("t5_l");
    chk("t5_masked", N'(int_out[1]), 5'd0);
    chk("t5_any0", N'(any_out), 5'd0);
    mask_v = 5'd0;
    #1;
    chk("t5_unmask", N'(int_out[1]), 5'd1);
    chk("t5_any1", N'(any_out), 5'd1);
    mask_v = 5'b00010;
    int_in[0] = 1'b1; repeat (2) tick("t5_lvl");
    chk("t5_lvl0", N'(int_out[0]), 5'd1);
    int_in[0] = 1'b0; mask_v = 5'd0; clear = EM;
    tick("t5_clr"); clear = 5'd0;
    repeat (2) tick("t5_idle");
`endif

    // 6 Asynchronous reset between edges with pending and overrun set.
    int_in[0] = 1'b1;
    int_in[1] = 1'b1; repeat (2) tick("t6_h1");
    int_in[1] = 1'b0; repeat (3) tick("t6_l1");
    int_in[1] = 1'b1; repeat (2) tick("t6_h2");
    int_in[1] = 1'b0; tick("t6_l2");
    chk("t6_pre_ovr", N'(overrun[1]), 5'd1);
    #2 reset_n = 1'b0;
    m_reset();
    #1;
    chk("t6_async_out", int_out, 5'd0);
    chk("t6_async_ovr", overrun, 5'd0);
    chk("t6_async_any", N'(any_out), 5'd0);
    tick("t6_rst"); tick("t6_rst");
    reset_n = 1'b1;
    tick("t6_r1"); chk("t6_lvl_lat1", N'(int_out[0]), 5'd0);
    tick("t6_r2"); chk("t6_lvl_lat2", N'(int_out[0]), 5'd1);

    // Randomized traffic; each source holds its level for at least 2 cycles.
    for (int i = 0; i < N; i++) hold[i] = 0;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] >= 2 && $urandom_range(0, 3) == 0) begin
          int_in[i] = ~int_in[i];
          hold[i] = 0;
        end else begin
          hold[i]++;
        end
      end
      clear = N'($urandom() & $urandom() & $urandom());
`ifdef INT_XBAR_MASK_EN
      mask_v = N'($urandom() & $urandom());
`endif
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
